store_merge_rmw: RTL and testbench
==================================

Name: store_merge_rmw

Overview:
Store-side counterpart of the load masking path. Takes a byte, halfword or word store request and merges the store data into the addressed memory word. Sub-word stores use a read-modify-write sequence. Sits between the MEM stage and a word-wide data memory with synchronous read latency. It also flags illegal size/alignment combinations.

Parameters:
ADDR_W, 32, byte-address width
MEM_RD_LAT, 1, cycles from MemRdEn to valid MemRdData (1..7)

Ports:
Clk  in  1  rising-edge clock
Reset_n  in  1  synchronous, active-low reset
StoreReq  in  1  request valid; accepted only when Ready=1
StoreAdr  in  ADDR_W  byte address of store
StoreData  in  32  store data, right-justified (byte in [7:0], half in [15:0])
Bytes2Store  in  2  0=word, 1=byte, 2=halfword, 3=illegal
Ready  out  1  high only in IDLE
Done  out  1  one-cycle pulse at completion (success or error)
Error  out  1  valid with Done; 1 = request rejected, no write
MemRdEn  out  1  one-cycle read strobe
MemWrEn  out  1  one-cycle write strobe
MemWordAdr  out  ADDR_W-2  word address = StoreAdr[ADDR_W-1:2] of the latched request
MemRdData  in  32  read data, valid MEM_RD_LAT cycles after MemRdEn
MemWrData  out  32  merged word

Behaviour:
- Clock and reset: single clock Clk. Reset_n is sampled only on the rising edge.
- Reset values: Ready=1, Done=0, Error=0, MemRdEn=0, MemWrEn=0, MemWordAdr=0, MemWrData=0. FSM goes to IDLE and the latency counter clears.
- Reset mid-operation: from any state, the FSM returns to IDLE. No MemWrEn is issued for the aborted request.
- Lane mapping is big-endian: offset 0 = [31:24], 1 = [23:16], 2 = [15:8], 3 = [7:0].
- Legality rules:
  - Word store requires offset 0.
  - Halfword store requires offset 0, 1 or 2. It occupies bytes off and off+1, so offset 1 covers [23:8].
  - Byte store is legal at any offset.
  - Bytes2Store=3 is always illegal.
- FSM states: IDLE, RD, RDWAIT, WR, ERR.
- IDLE:
  - If StoreReq is high, latch StoreAdr, StoreData and Bytes2Store. Ready drops the next cycle.
  - Illegal request -> ERR.
  - Word store -> WR. No memory read is performed.
  - Byte or half store -> RD.
- RD: MemRdEn=1 for one cycle and the counter loads MEM_RD_LAT. Next state is RDWAIT.
- RDWAIT:
  - The counter decrements each cycle.
  - When the counter reaches 0, capture MemRdData, replace only the addressed lanes with StoreData, register the result into MemWrData, then go to WR.
- WR:
  - MemWrEn=1 and Done=1 for one cycle, Error=0. Next state is IDLE.
  - For word stores, MemWrData = StoreData.
- ERR: Done=1 and Error=1 for one cycle, with no memory strobes. Next state is IDLE.
- Latency from the accept edge to Done:
  - Word store: Done in the next cycle.
  - Sub-word store: MEM_RD_LAT+2 cycles after accept.
  - Error: Done in the next cycle.
- Request handling while busy:
  - StoreReq is ignored while Ready=0. No queuing and no lost-request recovery; the upstream logic holds its request until it sees Ready.
  - A request asserted in the same cycle as Done is not accepted. It is accepted on the following cycle, when the FSM is back in IDLE.
- Hold values: MemWordAdr is stable from accept until IDLE. MemWrData holds its last value outside WR.
- Unused StoreData bits are ignored: [31:8] for byte, [31:16] for half.

Decomposition:
- Shared package: size encodings SZ_WORD=2'd0, SZ_BYTE=2'd1, SZ_HALF=2'd2, plus the state encoding. The load-side masking logic reuses the size encodings.
- One combinational sub-module, store_lane_merge: inputs are old word, store data, offset and size; outputs are the merged word and an illegal flag. It is reused for legality checking in IDLE.

Test Plan:
- Byte store: memory word 0x10 = 0x0ACFFB19, store 0xAA at 0x11 -> RD, then RDWAIT, then MemWrEn with MemWrData=0x0AAAFB19; Done at accept+3 for MEM_RD_LAT=1.
- Halfword stores on the same word:
  - 0x1234 at 0x12 -> 0x0ACF1234.
  - 0x1234 at 0x11 -> 0x0A123419.
  - 0x1234 at 0x10 -> 0x1234FB19.
- Byte store 0x55 at all offsets 0..3 of 0x0ACFFB19 -> 0x55CFFB19, 0x0A55FB19, 0x0ACF5519, 0x0ACFFB55.
- Word store 0xDEADBEEF at 0x10 -> no MemRdEn; MemWrEn and Done on the next cycle; MemWrData=0xDEADBEEF.
- Error cases, each giving Done=1 and Error=1 on the next cycle with MemRdEn=MemWrEn=0 throughout:
  - Halfword at offset 3.
  - Word at offset 2.
  - Bytes2Store=3.
- Reset and busy handling:
  - Reset_n=0 during RDWAIT -> IDLE the next cycle, Ready=1, no MemWrEn.
  - A second StoreReq held high during a busy period is accepted only on the cycle after Done.

Source files
------------

// File: rtl/store_merge_rmw_pkg.sv
// Shared encodings for the store merge path: access sizes and FSM states.
package store_merge_rmw_pkg;

  // Access size encoding shared with the load-side masking logic.
  typedef enum logic [1:0] {
    SZ_WORD = 2'd0,
    SZ_BYTE = 2'd1,
    SZ_HALF = 2'd2,
    SZ_ILL  = 2'd3
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RD     = 3'd1,
    ST_RDWAIT = 3'd2,
    ST_WR     = 3'd3,
    ST_ERR    = 3'd4
  } state_e;

  localparam int unsigned CNT_W = 3;

endpackage

// File: rtl/store_merge_rmw_if.sv
// Store request and data-memory bus between the MEM stage and store_merge_rmw.
interface store_merge_rmw_if #(
  parameter int ADDR_W = 32
) ();
  logic              StoreReq;
  logic [ADDR_W-1:0] StoreAdr;
  logic [31:0]       StoreData;
  logic [1:0]        Bytes2Store;
  logic              Ready;
  logic              Done;
  logic              Error;
  logic              MemRdEn;
  logic              MemWrEn;
  logic [ADDR_W-3:0] MemWordAdr;
  logic [31:0]       MemRdData;
  logic [31:0]       MemWrData;

  // Store unit side.
  modport slave (
    input  StoreReq, StoreAdr, StoreData, Bytes2Store, MemRdData,
    output Ready, Done, Error, MemRdEn, MemWrEn, MemWordAdr, MemWrData
  );

  // Requester / memory side.
  modport master (
    output StoreReq, StoreAdr, StoreData, Bytes2Store, MemRdData,
    input  Ready, Done, Error, MemRdEn, MemWrEn, MemWordAdr, MemWrData
  );
endinterface

// File: rtl/store_merge_rmw_lane_merge.sv
// Big-endian lane merge of right-justified store data into a memory word,
// plus size/alignment legality.
module store_lane_merge
  import store_merge_rmw_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] store_data,
  input  logic [1:0]  offset,
  input  size_e       size,
  output logic [31:0] merged_word,
  output logic        illegal
);

  // Replace only the addressed lanes; offset 0 is the most significant byte.
  always_comb begin
    merged_word = old_word;
    illegal     = 1'b0;
    case (size)
      SZ_WORD: begin
        merged_word = store_data;
        illegal     = (offset != 2'd0);
      end
      SZ_BYTE: begin
        case (offset)
          2'd0: merged_word[31:24] = store_data[7:0];
          2'd1: merged_word[23:16] = store_data[7:0];
          2'd2: merged_word[15:8]  = store_data[7:0];
          default: merged_word[7:0] = store_data[7:0];
        endcase
      end
      SZ_HALF: begin
        case (offset)
          2'd0: merged_word[31:16] = store_data[15:0];
          2'd1: merged_word[23:8]  = store_data[15:0];
          2'd2: merged_word[15:0]  = store_data[15:0];
          default: illegal = 1'b1;
        endcase
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/store_merge_rmw.sv
// Store unit: word stores written directly, sub-word stores via
// read-modify-write against a word memory with fixed read latency.
module store_merge_rmw
  import store_merge_rmw_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int MEM_RD_LAT = 1
) (
  input  logic             Clk,
  input  logic             Reset_n,
  store_merge_rmw_if.slave bus
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] adr_q, adr_d;
  logic [31:0]       data_q, data_d;
  size_e             size_q, size_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              rd_en_q, rd_en_d;
  logic              wr_en_q, wr_en_d;
  logic [31:0]       wr_data_q, wr_data_d;

  logic [1:0]  mrg_offset;
  size_e       mrg_size;
  logic [31:0] mrg_data;
  logic [31:0] mrg_word;
  logic        mrg_illegal;

  // One merge instance: checks the incoming request in IDLE, merges the latched one later.
  always_comb begin
    if (state_q == ST_IDLE) begin
      mrg_offset = bus.StoreAdr[1:0];
      mrg_size   = size_e'(bus.Bytes2Store);
      mrg_data   = bus.StoreData;
    end else begin
      mrg_offset = adr_q[1:0];
      mrg_size   = size_q;
      mrg_data   = data_q;
    end
  end

  store_lane_merge u_merge (
    .old_word    (bus.MemRdData),
    .store_data  (mrg_data),
    .offset      (mrg_offset),
    .size        (mrg_size),
    .merged_word (mrg_word),
    .illegal     (mrg_illegal)
  );

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    adr_d     = adr_q;
    data_d    = data_q;
    size_d    = size_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    rd_en_d   = 1'b0;
    wr_en_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.StoreReq) begin
          adr_d  = bus.StoreAdr;
          data_d = bus.StoreData;
          size_d = size_e'(bus.Bytes2Store);
          if (mrg_illegal) begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            error_d = 1'b1;
          end else if (size_e'(bus.Bytes2Store) == SZ_WORD) begin
            state_d   = ST_WR;
            wr_en_d   = 1'b1;
            done_d    = 1'b1;
            wr_data_d = bus.StoreData;
          end else begin
            state_d = ST_RD;
            rd_en_d = 1'b1;
          end
        end
      end
      ST_RD: begin
        cnt_d   = CNT_W'(MEM_RD_LAT);
        state_d = ST_RDWAIT;
      end
      ST_RDWAIT: begin
        cnt_d = cnt_q - 1'b1;
        // Capture on the cycle the count steps to zero, i.e. while read data is valid.
        if (cnt_q == CNT_W'(1)) begin
          wr_data_d = mrg_word;
          state_d   = ST_WR;
          wr_en_d   = 1'b1;
          done_d    = 1'b1;
        end
      end
      ST_WR:   state_d = ST_IDLE;
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    ready_d = (state_d == ST_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state_q   <= ST_IDLE;
      adr_q     <= '0;
      data_q    <= '0;
      size_q    <= SZ_WORD;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      adr_q     <= adr_d;
      data_q    <= data_d;
      size_q    <= size_d;
      cnt_q     <= cnt_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      error_q   <= error_d;
      rd_en_q   <= rd_en_d;
      wr_en_q   <= wr_en_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.Ready      = ready_q;
  assign bus.Done       = done_q;
  assign bus.Error      = error_q;
  assign bus.MemRdEn    = rd_en_q;
  assign bus.MemWrEn    = wr_en_q;
  assign bus.MemWordAdr = adr_q[ADDR_W-1:2];
  assign bus.MemWrData  = wr_data_q;

endmodule

// File: tb/tb_store_merge_rmw.sv
// Directed bench for store_merge_rmw with a one-cycle-latency memory model.
module tb_store_merge_rmw;

  logic        Clk;
  logic        Reset_n;
  logic [31:0] mem_word;
  int          checks;
  int          errors;

  store_merge_rmw_if #(.ADDR_W(32)) bus ();

  store_merge_rmw #(.ADDR_W(32), .MEM_RD_LAT(1)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Read data valid one cycle after the strobe; poison value otherwise.
  always @(posedge Clk) bus.MemRdData <= bus.MemRdEn ? mem_word : 32'hDEAD0000;

  typedef struct {
    logic [31:0] adr;
    logic [31:0] data;
    logic [1:0]  sz;
    logic [31:0] mem;
    logic        exp_err;
    logic        exp_rd;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wadr;
    int          exp_lat;
  } vec_t;

  vec_t vecs [14];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int          lat;
    int          rd_n;
    int          wr_n;
    logic [31:0] wd;
    logic        err;
    logic [31:0] wadr;
    logic        rdy1;
    @(negedge Clk);
    bus.StoreReq    = 1'b1;
    bus.StoreAdr    = v.adr;
    bus.StoreData   = v.data;
    bus.Bytes2Store = v.sz;
    mem_word        = v.mem;
    chk($sformatf("v%0d_ready_idle", idx), {31'd0, bus.Ready}, 32'd1);
    @(posedge Clk); #1;
    bus.StoreReq  = 1'b0;
    bus.StoreAdr  = 32'hFFFFFFFC;
    bus.StoreData = 32'hCAFEF00D;
    lat = 0; rd_n = 0; wr_n = 0; wd = '0; err = 1'b0; wadr = '0;
    rdy1 = bus.Ready;
    for (int c = 1; c <= 12; c++) begin
      if (bus.MemRdEn) rd_n++;
      if (bus.MemWrEn) begin
        wr_n++;
        wd = bus.MemWrData;
      end
      if (bus.Done) begin
        lat  = c;
        err  = bus.Error;
        wadr = {2'b00, bus.MemWordAdr};
        break;
      end
      @(posedge Clk); #1;
    end
    chk($sformatf("v%0d_done_lat", idx), lat, v.exp_lat);
    chk($sformatf("v%0d_error", idx), {31'd0, err}, {31'd0, v.exp_err});
    chk($sformatf("v%0d_rd_cnt", idx), rd_n, v.exp_rd ? 1 : 0);
    chk($sformatf("v%0d_wr_cnt", idx), wr_n, v.exp_err ? 0 : 1);
    if (!v.exp_err) chk($sformatf("v%0d_wdata", idx), wd, v.exp_wdata);
    chk($sformatf("v%0d_wadr", idx), wadr, v.exp_wadr);
    chk($sformatf("v%0d_busy", idx), {31'd0, rdy1}, 32'd0);
    @(posedge Clk); #1;
    chk($sformatf("v%0d_ready_after", idx), {31'd0, bus.Ready}, 32'd1);
    chk($sformatf("v%0d_quiet_after", idx), {30'd0, bus.Done, bus.MemWrEn}, 32'd0);
  endtask

  initial begin
    int rd_n;
    int wr_n;
    int d_n;
    logic [31:0] d_cyc [2];
    logic [31:0] d_dat [2];
    logic [31:0] d_adr [2];
    logic        rdy4;
    logic        rdy3;

    checks = 0;
    errors = 0;
    mem_word        = 32'h0ACFFB19;
    Reset_n         = 1'b0;
    bus.StoreReq    = 1'b0;
    bus.StoreAdr    = '0;
    bus.StoreData   = '0;
    bus.Bytes2Store = 2'd0;

    //          adr           data          sz    mem           err   rd    wdata         wadr   lat
    vecs[0]  = '{32'h11, 32'h000000AA, 2'd1, 32'h0ACFFB19, 1'b0, 1'b1, 32'h0AAAFB19, 32'h4, 3};
    vecs[1]  = '{32'h12, 32'h00001234, 2'd2, 32'h0ACFFB19, 1'b0, 1'b1, 32'h0ACF1234, 32'h4, 3};
    vecs[2]  = '{32'h11, 32'h00001234, 2'd2, 32'h0ACFFB19, 1'b0, 1'b1, 32'h0A123419, 32'h4, 3};
    vecs[3]  = '{32'h10, 32'h00001234, 2'd2, 32'h0ACFFB19, 1'b0, 1'b1, 32'h1234FB19, 32'h4, 3};
    vecs[4]  = '{32'h10, 32'h00000055, 2'd1, 32'h0ACFFB19, 1'b0, 1'b1, 32'h55CFFB19, 32'h4, 3};
    vecs[5]  = '{32'h11, 32'h00000055, 2'd1, 32'h0ACFFB19, 1'b0, 1'b1, 32'h0A55FB19, 32'h4, 3};
    vecs[6]  = '{32'h12, 32'h00000055, 2'd1, 32'h0ACFFB19, 1'b0, 1'b1, 32'h0ACF5519, 32'h4, 3};
    vecs[7]  = '{32'h13, 32'h00000055, 2'd1, 32'h0ACFFB19, 1'b0, 1'b1, 32'h0ACFFB55, 32'h4, 3};
    vecs[8]  = '{32'h10, 32'hDEADBEEF, 2'd0, 32'h0ACFFB19, 1'b0, 1'b0, 32'hDEADBEEF, 32'h4, 1};
    vecs[9]  = '{32'h13, 32'h00001234, 2'd2, 32'h0ACFFB19, 1'b1, 1'b0, 32'h0,        32'h4, 1};
    vecs[10] = '{32'h12, 32'hDEADBEEF, 2'd0, 32'h0ACFFB19, 1'b1, 1'b0, 32'h0,        32'h4, 1};
    vecs[11] = '{32'h10, 32'h000000AA, 2'd3, 32'h0ACFFB19, 1'b1, 1'b0, 32'h0,        32'h4, 1};
    vecs[12] = '{32'h23, 32'hFFFFFF55, 2'd1, 32'h11223344, 1'b0, 1'b1, 32'h11223355, 32'h8, 3};
    vecs[13] = '{32'h22, 32'hABCD5678, 2'd2, 32'h11223344, 1'b0, 1'b1, 32'h11225678, 32'h8, 3};

    // Reset values while reset is held.
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    chk("rst_ready", {31'd0, bus.Ready}, 32'd1);
    chk("rst_done", {31'd0, bus.Done}, 32'd0);
    chk("rst_error", {31'd0, bus.Error}, 32'd0);
    chk("rst_rden", {31'd0, bus.MemRdEn}, 32'd0);
    chk("rst_wren", {31'd0, bus.MemWrEn}, 32'd0);
    chk("rst_wadr", {2'b00, bus.MemWordAdr}, 32'd0);
    chk("rst_wdata", bus.MemWrData, 32'd0);
    Reset_n = 1'b1;

    for (int i = 0; i < 14; i++) run_vec(vecs[i], i);

    // Reset asserted while waiting for read data aborts the store.
    @(negedge Clk);
    bus.StoreReq = 1'b1; bus.StoreAdr = 32'h11; bus.StoreData = 32'hAA; bus.Bytes2Store = 2'd1;
    mem_word = 32'h0ACFFB19;
    @(posedge Clk); #1;
    bus.StoreReq = 1'b0;
    chk("abort_rden", {31'd0, bus.MemRdEn}, 32'd1);
    @(posedge Clk); #1;
    chk("abort_in_wait", {30'd0, bus.Ready, bus.MemWrEn}, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b0;
    @(posedge Clk); #1;
    chk("abort_ready", {31'd0, bus.Ready}, 32'd1);
    chk("abort_wren", {31'd0, bus.MemWrEn}, 32'd0);
    chk("abort_wdata", bus.MemWrData, 32'd0);
    @(negedge Clk);
    Reset_n = 1'b1;
    wr_n = 0; d_n = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge Clk); #1;
      if (bus.MemWrEn) wr_n++;
      if (bus.Done) d_n++;
    end
    chk("abort_no_write", wr_n, 0);
    chk("abort_no_done", d_n, 0);

    // Second request held high while busy is taken only after Done.
    @(negedge Clk);
    bus.StoreReq = 1'b1; bus.StoreAdr = 32'h11; bus.StoreData = 32'hAA; bus.Bytes2Store = 2'd1;
    mem_word = 32'h0ACFFB19;
    @(posedge Clk); #1;
    bus.StoreAdr = 32'h20; bus.StoreData = 32'hDEADBEEF; bus.Bytes2Store = 2'd0;
    rd_n = 0; wr_n = 0; d_n = 0; rdy3 = 1'b1; rdy4 = 1'b0;
    d_cyc[0] = '0; d_cyc[1] = '0; d_dat[0] = '0; d_dat[1] = '0; d_adr[0] = '0; d_adr[1] = '0;
    for (int c = 1; c <= 10; c++) begin
      if (c == 5) bus.StoreReq = 1'b0;
      if (c == 3) rdy3 = bus.Ready;
      if (c == 4) rdy4 = bus.Ready;
      if (bus.MemRdEn) rd_n++;
      if (bus.MemWrEn) wr_n++;
      if (bus.Done && d_n < 2) begin
        d_cyc[d_n] = c;
        d_dat[d_n] = bus.MemWrData;
        d_adr[d_n] = {2'b00, bus.MemWordAdr};
        d_n++;
      end
      @(posedge Clk); #1;
    end
    chk("busy_done_count", d_n, 2);
    chk("busy_first_cyc", d_cyc[0], 32'd3);
    chk("busy_first_data", d_dat[0], 32'h0AAAFB19);
    chk("busy_first_adr", d_adr[0], 32'h4);
    chk("busy_ready_at_done", {31'd0, rdy3}, 32'd0);
    chk("busy_ready_after", {31'd0, rdy4}, 32'd1);
    chk("busy_second_cyc", d_cyc[1], 32'd5);
    chk("busy_second_data", d_dat[1], 32'hDEADBEEF);
    chk("busy_second_adr", d_adr[1], 32'h8);
    chk("busy_rd_count", rd_n, 1);
    chk("busy_wr_count", wr_n, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
